pixel_framebuffer: RTL

Parametrised single-port-write, single-port-read framebuffer for the VGA path.
- Stores a COLOR_BITS-wide value per pixel (not a write-1-only bit).
- Reads are registered with 1-cycle latency so the array infers block RAM.
- A hardware clear engine fills the whole frame with a chosen colour.
- Sits between the drawing logic (write side) and the VGA timing generator (read side).

---
 rtl/pixel_framebuffer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pixel_framebuffer.sv
// Pixel framebuffer for the VGA path: one write port for the drawing logic,
// one registered read port for the timing generator, and a clear engine that
// fills the whole frame with a single colour.
module pixel_framebuffer #(
    parameter int unsigned FRAME_WIDTH  = 640,
    parameter int unsigned FRAME_HEIGHT = 480,
    parameter int unsigned COLOR_BITS   = 1,
    parameter int unsigned X_BITS       = 10,
    parameter int unsigned Y_BITS       = 10,
    parameter int unsigned ADDR_BITS    = 19
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [X_BITS-1:0]     readX,
    input  logic [Y_BITS-1:0]     readY,
    output logic [COLOR_BITS-1:0] color,
    input  logic [X_BITS-1:0]     writeX,
    input  logic [Y_BITS-1:0]     writeY,
    input  logic [COLOR_BITS-1:0] writeColor,
    input  logic                  wrEnable,
    input  logic                  clearReq,
    input  logic [COLOR_BITS-1:0] clearColor,
    output logic                  busy,
    output logic                  clearDone
);

    localparam int unsigned FramePixels = FRAME_WIDTH * FRAME_HEIGHT;
    localparam logic [ADDR_BITS-1:0] LastAddr = ADDR_BITS'(FramePixels - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    // Pixel storage; deliberately has no reset so it maps onto block RAM.
    logic [COLOR_BITS-1:0] r_mem [0:FramePixels-1];

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_BITS-1:0]  r_cnt;
    logic [ADDR_BITS-1:0]  w_cnt_next;
    logic [COLOR_BITS-1:0] r_clear_color;
    logic [COLOR_BITS-1:0] w_clear_color_next;
    logic                  r_done;
    logic                  w_done_next;

    logic [COLOR_BITS-1:0] r_rd_data;
    logic                  r_rd_valid;

    logic                  w_rd_in;
    logic                  w_wr_in;
    logic [ADDR_BITS-1:0]  w_rd_addr;
    logic [ADDR_BITS-1:0]  w_wr_addr;

    logic                  w_mem_we;
    logic [ADDR_BITS-1:0]  w_mem_addr;
    logic [COLOR_BITS-1:0] w_mem_data;

    // Bounds are checked at 32 bits so coordinates beyond the frame never alias.
    assign w_rd_in   = (32'(readX) < FRAME_WIDTH) && (32'(readY) < FRAME_HEIGHT);
    assign w_wr_in   = (32'(writeX) < FRAME_WIDTH) && (32'(writeY) < FRAME_HEIGHT);
    assign w_rd_addr = ADDR_BITS'(readY) * ADDR_BITS'(FRAME_WIDTH) + ADDR_BITS'(readX);
    assign w_wr_addr = ADDR_BITS'(writeY) * ADDR_BITS'(FRAME_WIDTH) + ADDR_BITS'(writeX);

    // Single write port shared between user writes (idle) and the clear engine.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Registered read: returns the pre-write contents on a same-address collision.
    always_ff @(posedge clk) begin
        if (w_rd_in) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    // Out-of-range marker for the read pipeline; also forces color to 0 in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_in;
        end
    end

    // Clear-engine state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_clear_color <= '0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_clear_color <= w_clear_color_next;
            r_done        <= w_done_next;
        end
    end

    // Next-state logic and write-port steering.
    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_clear_color_next = r_clear_color;
        w_done_next        = 1'b0;
        w_mem_we           = 1'b0;
        w_mem_addr         = w_wr_addr;
        w_mem_data         = writeColor;
        unique case (r_state)
            StIdle: begin
                // A write and a clear request on the same edge both take effect.
                w_mem_we = wrEnable && w_wr_in;
                if (clearReq) begin
                    w_state_next       = StClear;
                    w_cnt_next         = '0;
                    w_clear_color_next = clearColor;
                end
            end
            StClear: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_cnt;
                w_mem_data = r_clear_color;
                if (r_cnt == LastAddr) begin
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                    w_done_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign busy      = (r_state == StClear);
    assign clearDone = r_done;
    assign color     = r_rd_valid ? r_rd_data : '0;

endmodule
